// File: rtl/riscv_muldiv.sv
// riscv_muldiv: iterative RV32M multiply/divide execute unit.
//
// Sits behind the register file read ports; takes rs1/rs2 values, runs a
// 32-cycle radix-2 shift-add multiply or restoring divide on operand
// magnitudes, applies the result sign in DONE and issues one write-back.
//
// Optional build macro: RISCV_FAST_MUL_EN -- when defined, all multiplies
// are resolved by a single-cycle signed multiplier at latch time.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           new operation request (sampled only when idle)
//   kill            abort in-flight operation, suppresses done/wb_we
//   funct3          RV32M op select (MUL..REMU)
//   rs1_data/rs2_data  source operands
//   rd_in           destination register index
//   busy            high while not IDLE
//   done            one-cycle result-valid pulse
//   result          result value (held until the next done)
//   wb_addr, wb_we  register file write port (wb_we masked for x0)
module riscv_muldiv #(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      wb_addr,
  output logic            wb_we
);

  localparam int CW = $clog2(ITER);
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;

  logic [2:0]        op_q;
  logic [4:0]        rd_q;
  logic [XLEN-1:0]   opnd_q;     // multiplicand (mul) or divisor (div)
  logic [2*XLEN-1:0] acc_q;      // mul: {partial, multiplier}; div: {rem, dividend/quotient}
  logic [CW-1:0]     count_q;
  logic              neg_q;      // negate product / quotient
  logic              rneg_q;     // negate remainder
  logic              spec_q;
  logic [XLEN-1:0]   spec_res_q;
  logic [XLEN-1:0]   result_q;
  logic [4:0]        wb_addr_q;

  // ---------------- latch-time decode ----------------
  logic            is_div, a_sgn, b_sgn, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf, special, fast_mul, accept;
  logic [XLEN-1:0] spec_val;

  always_comb begin
    is_div   = funct3[2];
    a_sgn    = (funct3 == 3'd1) || (funct3 == 3'd2) || (funct3 == 3'd4) || (funct3 == 3'd6);
    b_sgn    = (funct3 == 3'd1) || (funct3 == 3'd4) || (funct3 == 3'd6);
    a_neg    = a_sgn & rs1_data[XLEN-1];
    b_neg    = b_sgn & rs2_data[XLEN-1];
    a_mag    = a_neg ? -rs1_data : rs1_data;
    b_mag    = b_neg ? -rs2_data : rs2_data;
    div_zero = is_div && (rs2_data == '0);
    // Only the signed ops (DIV/REM, funct3[0]=0) can overflow
    div_ovf  = is_div && !funct3[0] && (rs1_data == SMIN) && (rs2_data == '1);
    special  = div_zero || div_ovf;
    spec_val = '0;
    if (div_zero)     spec_val = funct3[1] ? rs1_data : '1;
    else if (div_ovf) spec_val = funct3[1] ? '0 : SMIN;
    accept   = (state == IDLE) && start && !kill;
  end

`ifdef RISCV_FAST_MUL_EN
  // Sign-extended operands: the low 2*XLEN bits of this product equal the
  // 33x33 signed product for every MUL variant.
  logic signed [2*XLEN-1:0] fm_a, fm_b, fm_p;
  always_comb begin
    fm_a     = {{XLEN{a_sgn & rs1_data[XLEN-1]}}, rs1_data};
    fm_b     = {{XLEN{b_sgn & rs2_data[XLEN-1]}}, rs2_data};
    fm_p     = fm_a * fm_b;
    fast_mul = !is_div;
  end
`else
  always_comb fast_mul = 1'b0;
`endif

  // ---------------- iteration datapath ----------------
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_hi;
  logic [XLEN-1:0]   div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] div_next;

  always_comb begin
    // Shift-add: add multiplicand into the upper half when the current
    // multiplier LSB is set, then shift the whole accumulator right.
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next = {mul_sum, acc_q[XLEN-1:1]};
    // Restoring divide: shift {rem, dividend} left, trial-subtract divisor.
    div_hi   = acc_q[2*XLEN-1:XLEN-1];
    div_ge   = div_hi >= {1'b0, opnd_q};
    div_diff = div_hi[XLEN-1:0] - opnd_q;
    div_next = div_ge ? {div_diff, acc_q[XLEN-2:0], 1'b1}
                      : {div_hi[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
  end

  // ---------------- result select / sign fix ----------------
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s, rem_s, final_val;

  always_comb begin
    prod_s = neg_q  ? -acc_q : acc_q;
    quo_s  = neg_q  ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_s  = rneg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    unique case (op_q)
      3'd0:             final_val = prod_s[XLEN-1:0];
      3'd1, 3'd2, 3'd3: final_val = prod_s[2*XLEN-1:XLEN];
      3'd4, 3'd5:       final_val = quo_s;
      default:          final_val = rem_s;
    endcase
    if (spec_q) final_val = spec_res_q;
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = (special || fast_mul) ? DONE : RUN;
      RUN: begin
        if (kill)                               state_nxt = IDLE;
        else if (count_q == CW'(ITER - 1))      state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q       <= '0;
      rd_q       <= '0;
      opnd_q     <= '0;
      acc_q      <= '0;
      count_q    <= '0;
      neg_q      <= 1'b0;
      rneg_q     <= 1'b0;
      spec_q     <= 1'b0;
      spec_res_q <= '0;
      result_q   <= '0;
      wb_addr_q  <= '0;
    end else begin
      if (accept) begin
        op_q       <= funct3;
        rd_q       <= rd_in;
        opnd_q     <= is_div ? b_mag : a_mag;
        acc_q      <= {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
        count_q    <= '0;
        // Non-special divides always have a nonzero divisor here
        neg_q      <= a_neg ^ b_neg;
        rneg_q     <= a_neg;
        spec_q     <= special;
        spec_res_q <= spec_val;
`ifdef RISCV_FAST_MUL_EN
        if (fast_mul) begin
          acc_q <= fm_p;
          neg_q <= 1'b0;
        end
`endif
      end else if (state == RUN && !kill) begin
        count_q <= count_q + 1'b1;
        acc_q   <= op_q[2] ? div_next : mul_next;
      end
      if (state == DONE && !kill) begin
        result_q  <= final_val;
        wb_addr_q <= rd_q;
      end
    end
  end

  // ---------------- outputs ----------------
  always_comb begin
    busy    = (state != IDLE);
    done    = (state == DONE) && !kill && !rst;
    result  = done ? final_val : result_q;
    wb_addr = done ? rd_q : wb_addr_q;
    wb_we   = done && (rd_q != 5'd0);
  end

endmodule

// File: tb/tb_riscv_muldiv.sv
// Self-checking bench for riscv_muldiv: a reference model computes results
// with plain integer arithmetic; one negedge process compares busy, done,
// wb_we, result and wb_addr against the expected timeline every cycle.
module tb_riscv_muldiv;

  logic        clk = 1'b0;
  logic        rst, start, kill;
  logic [2:0]  funct3;
  logic [31:0] rs1_data, rs2_data, result;
  logic [4:0]  rd_in, wb_addr;
  logic        busy, done, wb_we;

  riscv_muldiv dut (
    .clk(clk), .rst(rst), .start(start), .kill(kill), .funct3(funct3),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_in(rd_in),
    .busy(busy), .done(done), .result(result), .wb_addr(wb_addr), .wb_we(wb_we)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // expected timeline of the single outstanding op
  int          exp_s    = -1;
  int          busy_end = -1;
  int          done_due = -1;
  int          rst_at   = -1;
  logic [31:0] exp_res  = '0;
  logic [4:0]  exp_rd   = '0;
  logic [31:0] hold_res = '0;
  logic [4:0]  hold_addr = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    int ia, ib;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = longint'({32'b0, a}); ub = longint'({32'b0, b});
    ia = a; ib = b;
    p = '0;
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 0;
`ifdef RISCV_FAST_MUL_EN
    if (!f[2]) return 0;
`endif
    return 32;
  endfunction

  // per-cycle compare
  always @(negedge clk) begin
    logic e_busy, e_done;
    e_busy = (exp_s >= 0) && (cyc >= exp_s) && (cyc <= busy_end);
    e_done = (cyc == done_due);
    if (cyc == rst_at) begin
      hold_res  = '0;
      hold_addr = '0;
    end
    chk("busy",  32'(busy),  32'(e_busy));
    chk("done",  32'(done),  32'(e_done));
    chk("wb_we", 32'(wb_we), 32'(e_done && exp_rd != 0));
    if (e_done) begin
      chk("result",  result,       exp_res);
      chk("wb_addr", 32'(wb_addr), 32'(exp_rd));
      hold_res  = exp_res;
      hold_addr = exp_rd;
    end else begin
      chk("result_hold",  result,       hold_res);
      chk("wb_addr_hold", 32'(wb_addr), 32'(hold_addr));
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic launch(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    funct3 = f; rs1_data = a; rs2_data = b; rd_in = rd; start = 1'b1;
    exp_s    = cyc + 1;
    done_due = exp_s + lat(f, a, b);
    busy_end = done_due;
    exp_res  = model(f, a, b);
    exp_rd   = rd;
    step();
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (cyc <= busy_end + 1 && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) begin
      errors++;
      $display("FAIL timeout: got no idle expected idle within 200 cycles");
    end
  endtask

  task automatic run(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] rd, input logic [31:0] lit);
    chk("model_pin", model(f, a, b), lit);
    launch(f, a, b, rd);
    wait_idle();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; kill = 1'b0; funct3 = '0;
    rs1_data = '0; rs2_data = '0; rd_in = '0;
    repeat (3) step();
    rst = 1'b0;
    step();

    // multiplies
    run(3'd0, 32'd7,         32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB);
    run(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1,  32'h4000_0000);
    run(3'd3, 32'h8000_0000, 32'h8000_0000, 5'd2,  32'h4000_0000);
    run(3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 5'd3,  32'hFFFF_FFFF);
    run(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 5'd6,  model(3'd1, 32'h1234_5678, 32'h9ABC_DEF0));
    // divides
    run(3'd4, 32'hFFFF_FFF9, 32'd2,         5'd7,  32'hFFFF_FFFD);
    run(3'd6, 32'hFFFF_FFF9, 32'd2,         5'd8,  32'hFFFF_FFFF);
    run(3'd5, 32'd100,       32'd7,         5'd9,  32'd14);
    run(3'd7, 32'd100,       32'd7,         5'd10, 32'd2);
    run(3'd6, 32'd7,         32'hFFFF_FFFE, 5'd11, 32'd1);
    // special cases (single cycle)
    run(3'd5, 32'd100,       32'd0,         5'd12, 32'hFFFF_FFFF);
    run(3'd7, 32'd100,       32'd0,         5'd13, 32'd100);
    run(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h8000_0000);
    run(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'd0);

    // kill during cycle 10, new op accepted right after
    launch(3'd4, 32'd1000, 32'd3, 5'd16);
    repeat (9) step();
    kill = 1'b1; busy_end = cyc; done_due = -1;
    step();
    kill = 1'b0;
    launch(3'd5, 32'd100, 32'd7, 5'd17);
    wait_idle();

    // reset in cycle 20 of an operation
    launch(3'd0, 32'd9, 32'd9, 5'd18);
    repeat (19) step();
    rst = 1'b1; busy_end = cyc; done_due = -1; rst_at = cyc + 1;
    step();
    rst = 1'b0;
    step();

    // x0 destination, plus a start while busy that must be ignored
    launch(3'd0, 32'd3, 32'd5, 5'd0);
    repeat (3) step();
    start = 1'b1; funct3 = 3'd5; rs1_data = 32'd50; rs2_data = 32'd0; rd_in = 5'd20;
    step();
    start = 1'b0;
    wait_idle();
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/riscv_muldiv.md
Name: riscv_muldiv

Overview:
Iterative RV32M multiply/divide execute unit that sits directly downstream of the register file read ports. It consumes the two source-operand values read from the register file, runs a multi-cycle shift-add or restoring-divide sequence, and produces one write-back request (address, data, enable) for the register file write port. The pipeline stalls on busy while an operation is in flight.

Parameters:
XLEN, 32, operand/result width; only 32 is supported.
ITER, 32, iterations for a normal operation; fixed equal to XLEN.

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
start  input  1  request a new operation; sampled only when busy=0
kill  input  1  abort the in-flight operation (pipeline flush)
funct3  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
rs1_data  input  32  operand A from register file rd1
rs2_data  input  32  operand B from register file rd2
rd_in  input  5  destination register index
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse: result valid
result  output  32  operation result
wb_addr  output  5  write-back address, to the register file write address
wb_we  output  1  write-back enable, equal to done & (wb_addr != 0)

Behaviour:
- Reset: state=IDLE; busy, done and wb_we = 0; result=0; wb_addr=0; all internal accumulators and counters = 0.
- States: IDLE, RUN, DONE.
- IDLE: start=1 latches funct3, rd_in and operands at the clock edge. A normal operation goes to RUN with count=0. A special-case operation goes straight to DONE. start=0 stays in IDLE.
- Signed handling: operands are converted to magnitudes at latch time according to funct3. MULHSU treats A as signed and B as unsigned. The result sign is applied in DONE.
- RUN: one iteration per cycle with count 0..31. Multiply is radix-2 shift-add into a 64-bit accumulator. Divide is restoring, one quotient bit per cycle. When count=31, the next state is DONE.
- DONE, for one cycle:
  - done=1.
  - result selects one of: low 32 bits of the product (MUL); high 32 bits (MULH, MULHSU, MULHU); the quotient (DIV, DIVU); or the remainder (REM, REMU).
  - The next state is IDLE.
- result and wb_addr hold their values until the next DONE.
- Latency for a normal operation: start edge at cycle 0, RUN for cycles 1..32, done in cycle 33. busy goes high the cycle after start is accepted.
- Special cases. Each resolves in 1 cycle (done in the cycle after the start edge) and does not iterate:
  - Divide by zero: DIV and DIVU return 0xFFFFFFFF; REM and REMU return rs1_data.
  - Signed overflow (DIV with 0x80000000 / 0xFFFFFFFF): DIV returns 0x80000000; REM returns 0.
- Sign rules: the quotient is negative iff the operand signs differ and the divisor is nonzero. The remainder takes the sign of the dividend. All arithmetic is modulo 2^32 / 2^64.
- start while busy=1 is ignored. No queueing.
- kill=1 in RUN or DONE:
  - Next state is IDLE.
  - done and wb_we stay 0 in that cycle and do not fire later.
  - kill overrides the DONE pulse in the same cycle.
  - kill in IDLE has no effect, and takes priority over a simultaneous start.
- rst mid-operation returns to the reset state next edge. No done is produced.
- wb_addr=0 (x0): done still pulses but wb_we=0.

Optional Feature:
RISCV_FAST_MUL_EN. When defined, MUL, MULH, MULHSU and MULHU are computed by a single-cycle 33x33 signed multiplier at latch time and go straight to DONE (done in the cycle after start). Divide is unchanged. When undefined, all multiplies use the 32-cycle iterative path and no hardware multiplier is inferred.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD (-3), rd=5 -> done exactly 33 cycles after start (1 cycle if RISCV_FAST_MUL_EN); result=0xFFFFFFEB; wb_addr=5; wb_we=1; busy high in between.
- MULH 0x80000000*0x80000000 -> 0x40000000; MULHU same operands -> 0x40000000; MULHSU 0xFFFFFFFF*0x00000002 -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2; each 33-cycle latency.
- DIVU 100/0 -> 0xFFFFFFFF and REMU 100/0 -> 100; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM -> 0; each with done 1 cycle after start.
- Start DIV, assert kill at cycle 10 -> busy=0 at cycle 11, no done/wb_we ever. A new start at cycle 11 is accepted and completes correctly. Asserting rst at cycle 20 of an operation -> all outputs 0 next cycle.
- MUL with rd_in=0 -> done=1, wb_we=0. A second start during busy -> ignored, only one done observed.
